// File: rtl/disp_pkg.sv
// disp_pkg: segment order, hex glyph table and scan timing helpers for display_mux_n
package disp_pkg;
  localparam int SEG_A = 0, SEG_B = 1, SEG_C = 2, SEG_D = 3, SEG_E = 4, SEG_F = 5, SEG_G = 6;
  localparam int SEG_W = 7;
  typedef logic [SEG_W-1:0] seg_t;
  // glyphs packed as {g,f,e,d,c,b,a}, entry 0 in the low bits
  localparam logic [16*SEG_W-1:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic seg_t hex_glyph(input logic [3:0] n);
    return GLYPHS[n*SEG_W +: SEG_W];
  endfunction
  function automatic int phase_cyc(input int clk_freq, input int frame_hz, input int nd);
    int c = clk_freq / (frame_hz * nd * 16);
    return c < 1 ? 1 : c;
  endfunction
  function automatic int blink_cyc(input int clk_freq, input int blink_hz);
    int c = clk_freq / (2 * blink_hz);
    return c < 1 ? 1 : c;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble to 7-segment {g,f,e,d,c,b,a}; nib in, seg out
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  assign seg = hex_glyph(nib);
endmodule

// File: rtl/display_mux_n.sv
// display_mux_n: N-digit multiplexed 7-seg driver with frame shadowing, LZ blanking, blink, DP and PWM
// Ports: CLK/RST (sync, active-high); DIGITS, DP_IN, BLINK_MASK, LZ_BLANK, BRIGHT in;
//        CA one-hot digit, AN {g..a}, DP, FRAME_TICK out (CA/AN/DP inverted when ACTIVE_LOW)
module display_mux_n
  import disp_pkg::*;
#(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int NUM_DIGITS = 4,
  parameter int FRAME_HZ   = 250,
  parameter int BLINK_HZ   = 2,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] DIGITS,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic [NUM_DIGITS-1:0]   BLINK_MASK,
  input  logic                    LZ_BLANK,
  input  logic [3:0]              BRIGHT,
  output logic [NUM_DIGITS-1:0]   CA,
  output logic [6:0]              AN,
  output logic                    DP,
  output logic                    FRAME_TICK
);
  localparam int PC = phase_cyc(CLK_FREQ, FRAME_HZ, NUM_DIGITS);
  localparam int BC = blink_cyc(CLK_FREQ, BLINK_HZ);
  localparam int PW = PC > 1 ? $clog2(PC) : 1;
  localparam int BW = BC > 1 ? $clog2(BC) : 1;
  localparam int SW = $clog2(NUM_DIGITS);
  logic [PW-1:0] presc;
  logic [3:0] phase, phase_q, br_sh;
  logic [SW-1:0] slot, slot_q;
  logic [BW-1:0] blink_cnt;
  logic blink_on, valid_q, lz_sh, ft_r, dp_r;
  logic [4*NUM_DIGITS-1:0] dig_sh;
  logic [NUM_DIGITS-1:0] dp_sh, bm_sh, lz_hit, ca_r;
  logic [6:0] an_r;
  seg_t seg;
  logic load, presc_end, blanked, lit;
  seg7_decode u_dec (.nib(dig_sh[{slot_q, 2'b00} +: 4]), .seg(seg));
  // digit s is a leading zero when it and every more-significant nibble are 0
  always_comb begin
    lz_hit = '0;
    for (int s = 1; s < NUM_DIGITS; s++) lz_hit[s] = (dig_sh >> (4 * s)) == '0;
  end
  assign load      = presc == '0 && phase == '0 && slot == '0;
  assign presc_end = presc == PW'(PC - 1);
  assign blanked   = (bm_sh[slot_q] & ~blink_on) | (lz_sh & lz_hit[slot_q]);
  assign lit       = phase_q <= br_sh && !blanked;
  // outputs use the previous cycle's counters so each slot spans exactly its 16 phases
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0; phase <= '0; slot <= '0;
      dig_sh <= '0; dp_sh <= '0; bm_sh <= '0; lz_sh <= 1'b0; br_sh <= '0;
      blink_cnt <= '0; blink_on <= 1'b1;
      slot_q <= '0; phase_q <= '0; valid_q <= 1'b0;
      ca_r <= '0; an_r <= '0; dp_r <= 1'b0; ft_r <= 1'b0;
    end else begin
      presc <= presc_end ? '0 : presc + 1'b1;
      if (presc_end) phase <= phase + 1'b1;
      if (presc_end && phase == 4'd15) slot <= slot == SW'(NUM_DIGITS - 1) ? '0 : slot + 1'b1;
      if (load) begin
        dig_sh <= DIGITS; dp_sh <= DP_IN; bm_sh <= BLINK_MASK; lz_sh <= LZ_BLANK; br_sh <= BRIGHT;
      end
      ft_r <= load;
      blink_cnt <= blink_cnt == BW'(BC - 1) ? '0 : blink_cnt + 1'b1;
      if (blink_cnt == BW'(BC - 1)) blink_on <= ~blink_on;
      slot_q  <= slot;
      phase_q <= phase;
      valid_q <= 1'b1;
      ca_r <= valid_q ? NUM_DIGITS'(1) << slot_q : '0;
      an_r <= valid_q && lit ? seg : '0;
      dp_r <= valid_q && lit && dp_sh[slot_q];
    end
  end
  assign CA         = {NUM_DIGITS{ACTIVE_LOW}} ^ ca_r;
  assign AN         = {7{ACTIVE_LOW}} ^ an_r;
  assign DP         = ACTIVE_LOW ^ dp_r;
  assign FRAME_TICK = ft_r;
endmodule

// File: tb/tb_display_mux_n.sv
// tb_display_mux_n: directed self-checking bench for display_mux_n (active-high and active-low builds)
module tb_display_mux_n;
  logic CLK = 1'b0, RST = 1'b1;
  logic [15:0] DIGITS;
  logic [3:0] DP_IN, BLINK_MASK, BRIGHT;
  logic LZ_BLANK;
  logic [3:0] ca, ca_n;
  logic [6:0] an, an_n;
  logic dp, dp_n, ft, ft_n;
  int cyc = 0, n_chk = 0, n_fail = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;
  display_mux_n #(.CLK_FREQ(1280), .NUM_DIGITS(4), .FRAME_HZ(10), .BLINK_HZ(5), .ACTIVE_LOW(1'b0)) dut (
    .CLK(CLK), .RST(RST), .DIGITS(DIGITS), .DP_IN(DP_IN), .BLINK_MASK(BLINK_MASK), .LZ_BLANK(LZ_BLANK),
    .BRIGHT(BRIGHT), .CA(ca), .AN(an), .DP(dp), .FRAME_TICK(ft));
  display_mux_n #(.CLK_FREQ(1280), .NUM_DIGITS(4), .FRAME_HZ(10), .BLINK_HZ(5), .ACTIVE_LOW(1'b1)) dut_n (
    .CLK(CLK), .RST(RST), .DIGITS(DIGITS), .DP_IN(DP_IN), .BLINK_MASK(BLINK_MASK), .LZ_BLANK(LZ_BLANK),
    .BRIGHT(BRIGHT), .CA(ca_n), .AN(an_n), .DP(dp_n), .FRAME_TICK(ft_n));
  task automatic wait_to(input int n);
    int g = 0;
    while (cyc != n && g < 3000) begin
      @(negedge CLK);
      g++;
    end
    n_chk++;
    assert (cyc == n) else begin
      n_fail++;
      $error("FAIL wait_%0d: cyc=%0d expected %0d", n, cyc, n);
    end
  endtask
  task automatic chk(input string tag, input logic eft, input logic [3:0] eca, input logic [6:0] ean, input logic edp);
    n_chk++;
    assert ({ft, ca, an, dp} === {eft, eca, ean, edp}) else begin
      n_fail++;
      $error("FAIL %s: got ft=%b ca=%b an=%h dp=%b expected ft=%b ca=%b an=%h dp=%b", tag, ft, ca, an, dp, eft, eca, ean, edp);
    end
    n_chk++;
    assert ({ft_n, ca_n, an_n, dp_n} === {eft, ~eca, ~ean, ~edp}) else begin
      n_fail++;
      $error("FAIL %s_low: got ft=%b ca=%b an=%h dp=%b expected ft=%b ca=%b an=%h dp=%b", tag, ft_n, ca_n, an_n, dp_n, eft, ~eca, ~ean, ~edp);
    end
  endtask
  initial begin
    DIGITS = 16'h1234; BRIGHT = 4'd15; DP_IN = '0; BLINK_MASK = '0; LZ_BLANK = 1'b0;
    repeat (20) @(negedge CLK);
    chk("reset", 0, 4'b0000, 7'h00, 0);
    RST = 1'b0;
    wait_to(1);    chk("tick0", 1, 4'b0000, 7'h00, 0);
    wait_to(2);    chk("s0_first", 0, 4'b0001, 7'h66, 0);
    wait_to(33);   chk("s0_last", 0, 4'b0001, 7'h66, 0);
    wait_to(34);   chk("s1_3", 0, 4'b0010, 7'h4F, 0);
    wait_to(70);   chk("s2_2", 0, 4'b0100, 7'h5B, 0);
    wait_to(129);  chk("s3_1_tick", 1, 4'b1000, 7'h06, 0);
    wait_to(130);  chk("f1_s0", 0, 4'b0001, 7'h66, 0);
    wait_to(170);  DIGITS = 16'hABCD;
    wait_to(180);  chk("tear_s1", 0, 4'b0010, 7'h4F, 0);
    wait_to(200);  chk("tear_s2", 0, 4'b0100, 7'h5B, 0);
    wait_to(240);  chk("tear_s3", 0, 4'b1000, 7'h06, 0);
    wait_to(257);  chk("tear_tick", 1, 4'b1000, 7'h06, 0);
    wait_to(260);  chk("hex_d", 0, 4'b0001, 7'h5E, 0);
    wait_to(300);  chk("hex_C", 0, 4'b0010, 7'h39, 0);
    wait_to(330);  chk("hex_b", 0, 4'b0100, 7'h7C, 0);
    wait_to(360);  chk("hex_A", 0, 4'b1000, 7'h77, 0);
    DIGITS = 16'h0007; LZ_BLANK = 1'b1; DP_IN = 4'b1001;
    wait_to(385);  chk("hex_A_tick", 1, 4'b1000, 7'h77, 0);
    wait_to(390);  chk("lz7_s0", 0, 4'b0001, 7'h07, 1);
    wait_to(430);  chk("lz7_s1", 0, 4'b0010, 7'h00, 0);
    wait_to(460);  chk("lz7_s2", 0, 4'b0100, 7'h00, 0);
    wait_to(500);  chk("lz7_s3_dp", 0, 4'b1000, 7'h00, 0);
    DIGITS = 16'h0000; DP_IN = '0;
    wait_to(520);  chk("lz0_s0", 0, 4'b0001, 7'h3F, 0);
    wait_to(560);  chk("lz0_s1", 0, 4'b0010, 7'h00, 0);
    wait_to(620);  chk("lz0_s3", 0, 4'b1000, 7'h00, 0);
    DIGITS = 16'h0105;
    wait_to(650);  chk("lz105_s0", 0, 4'b0001, 7'h6D, 0);
    wait_to(680);  chk("lz105_s1", 0, 4'b0010, 7'h3F, 0);
    wait_to(720);  chk("lz105_s2", 0, 4'b0100, 7'h06, 0);
    wait_to(750);  chk("lz105_s3", 0, 4'b1000, 7'h00, 0);
    LZ_BLANK = 1'b0; DIGITS = 16'h1234; BLINK_MASK = 4'b0010; DP_IN = 4'b0100;
    wait_to(810);  chk("blink_on_s1", 0, 4'b0010, 7'h4F, 0);
    wait_to(840);  chk("dp_on_s2", 0, 4'b0100, 7'h5B, 1);
    wait_to(910);  chk("blink_off_s0", 0, 4'b0001, 7'h66, 0);
    wait_to(940);  chk("blink_off_s1", 0, 4'b0010, 7'h00, 0);
    wait_to(970);  chk("dp_steady_s2", 0, 4'b0100, 7'h5B, 1);
    BRIGHT = 4'd3;
    wait_to(1025); chk("f7_tick", 1, 4'b1000, 7'h06, 0);
    wait_to(1026); chk("pwm_ph0", 0, 4'b0001, 7'h66, 0);
    wait_to(1033); chk("pwm_ph3", 0, 4'b0001, 7'h66, 0);
    wait_to(1034); chk("pwm_ph4", 0, 4'b0001, 7'h00, 0);
    wait_to(1057); chk("pwm_ph15", 0, 4'b0001, 7'h00, 0);
    wait_to(1090); chk("pwm_s2_lit", 0, 4'b0100, 7'h5B, 1);
    wait_to(1098); chk("pwm_s2_dark", 0, 4'b0100, 7'h00, 0);
    wait_to(1225); chk("pre_rst_s2", 0, 4'b0100, 7'h5B, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst", 0, 4'b0000, 7'h00, 0);
    RST = 1'b0;
    wait_to(1);    chk("rst_tick", 1, 4'b0000, 7'h00, 0);
    wait_to(2);    chk("rst_s0", 0, 4'b0001, 7'h66, 0);
    wait_to(34);   chk("rst_s1", 0, 4'b0010, 7'h4F, 0);
    wait_to(70);   chk("rst_s2", 0, 4'b0100, 7'h5B, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
